tl_ul_buffer: RTL and testbench



---
 rtl/tl_ul_pkg.sv | 44 ++++
 rtl/tl_queue.sv | 75 +++++++
 rtl/tl_ul_buffer.sv | 70 +++++++
 tb/tb_tl_ul_buffer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/tl_ul_pkg.sv
// tl_ul_pkg: shared TileLink-UL definitions for the memory-port buffer.
// Contents: field widths, TL-UL opcode encodings, and the packed channel-A
// and channel-D beat structs used by tl_ul_buffer and its testbench.
package tl_ul_pkg;

   localparam int TL_ADDR_W = 31;
   localparam int TL_DATA_W = 32;
   localparam int TL_MASK_W = TL_DATA_W / 8;
   localparam int TL_SRC_W  = 2;
   localparam int TL_SIZE_W = 3;
   localparam int TL_SINK_W = 1;

   // Channel A opcodes
   localparam logic [2:0] TL_A_PUT_FULL_DATA    = 3'd0;
   localparam logic [2:0] TL_A_PUT_PARTIAL_DATA = 3'd1;
   localparam logic [2:0] TL_A_GET              = 3'd4;

   // Channel D opcodes
   localparam logic [2:0] TL_D_ACCESS_ACK      = 3'd0;
   localparam logic [2:0] TL_D_ACCESS_ACK_DATA = 3'd1;

   typedef struct packed {
      logic [2:0]           opcode;
      logic [2:0]           param;
      logic [TL_SIZE_W-1:0] size;
      logic [TL_SRC_W-1:0]  source;
      logic [TL_ADDR_W-1:0] address;
      logic [TL_MASK_W-1:0] mask;
      logic [TL_DATA_W-1:0] data;
      logic                 corrupt;
   } tl_a_t;

   typedef struct packed {
      logic [2:0]           opcode;
      logic [1:0]           param;
      logic [TL_SIZE_W-1:0] size;
      logic [TL_SRC_W-1:0]  source;
      logic [TL_SINK_W-1:0] sink;
      logic                 denied;
      logic [TL_DATA_W-1:0] data;
      logic                 corrupt;
   } tl_d_t;

endpackage

// File: rtl/tl_queue.sv
// tl_queue: generic circular valid/ready FIFO carrying payload type T.
// Ports:
//   clock, reset          - rising-edge clock, synchronous active-high reset
//   in_valid/in_ready/in_bits    - push side
//   out_valid/out_ready/out_bits - pop side, head entry driven from registers
// Handshake: a beat transfers on a rising edge where valid && ready. in_ready
// depends only on the registered count, so there is no combinational path
// from out_ready to in_ready. A pushed beat becomes visible on out_* after
// the push edge (no bypass). Storage is not reset; only pointers and count.
module tl_queue #(
   parameter type T     = logic [7:0],
   parameter int  DEPTH = 2
) (
   input  logic clock,
   input  logic reset,
   input  logic in_valid,
   output logic in_ready,
   input  T     in_bits,
   output logic out_valid,
   input  logic out_ready,
   output T     out_bits
);
   import tl_ul_pkg::*;

   // A one-entry queue still needs a one-bit pointer to index storage.
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   T                 storage [DEPTH];
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [CNT_W-1:0] count;
   logic             push;
   logic             pop;

   // Explicit wrap so non-power-of-two depths work.
   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
      return (ptr == LAST_PTR) ? '0 : ptr + PTR_W'(1);
   endfunction

   assign in_ready  = (count != FULL_CNT);
   assign out_valid = (count != '0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;
   assign out_bits  = storage[head];

   always_ff @(posedge clock) begin
      if (push) begin
         storage[tail] <= in_bits;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) begin
            tail <= next_ptr(tail);
         end
         if (pop) begin
            head <= next_ptr(head);
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/tl_ul_buffer.sv
// tl_ul_buffer: TileLink-UL decoupling buffer on the core's memory port.
// One tl_queue on channel A (master -> slave), one on channel D
// (slave -> master); every combinational path through the port is cut.
// Ports:
//   clock, reset                            - clock, synchronous active-high reset
//   a_in_valid/a_in_ready/a_in_bits         - A beats from the master
//   a_out_valid/a_out_ready/a_out_bits      - registered A beats to the slave
//   d_in_valid/d_in_ready/d_in_bits         - D beats from the slave
//   d_out_valid/d_out_ready/d_out_bits      - D beats to the master
//   idle                                    - both queues empty
module tl_ul_buffer
   import tl_ul_pkg::*;
#(
   parameter int A_DEPTH = 2,
   parameter int D_DEPTH = 2,
   parameter int ADDR_W  = TL_ADDR_W,
   parameter int DATA_W  = TL_DATA_W,
   parameter int SRC_W   = TL_SRC_W
) (
   input  logic  clock,
   input  logic  reset,
   input  logic  a_in_valid,
   output logic  a_in_ready,
   input  tl_a_t a_in_bits,
   output logic  a_out_valid,
   input  logic  a_out_ready,
   output tl_a_t a_out_bits,
   input  logic  d_in_valid,
   output logic  d_in_ready,
   input  tl_d_t d_in_bits,
   output logic  d_out_valid,
   input  logic  d_out_ready,
   output tl_d_t d_out_bits,
   output logic  idle
);

   // The beat structs are sized by the package; reject mismatched overrides.
   if (ADDR_W != TL_ADDR_W || DATA_W != TL_DATA_W || SRC_W != TL_SRC_W) begin : g_width_check
      $error("tl_ul_buffer: width parameters must match tl_ul_pkg");
   end
   if (A_DEPTH < 1 || D_DEPTH < 1) begin : g_depth_check
      $error("tl_ul_buffer: queue depths must be at least 1");
   end

   tl_queue #(.T(tl_a_t), .DEPTH(A_DEPTH)) u_a_queue (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (a_in_valid),
      .in_ready  (a_in_ready),
      .in_bits   (a_in_bits),
      .out_valid (a_out_valid),
      .out_ready (a_out_ready),
      .out_bits  (a_out_bits)
   );

   tl_queue #(.T(tl_d_t), .DEPTH(D_DEPTH)) u_d_queue (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (d_in_valid),
      .in_ready  (d_in_ready),
      .in_bits   (d_in_bits),
      .out_valid (d_out_valid),
      .out_ready (d_out_ready),
      .out_bits  (d_out_bits)
   );

   // out_valid is exactly "count != 0", so this is both counts being zero.
   assign idle = !a_out_valid && !d_out_valid;

endmodule

// File: tb/tb_tl_ul_buffer.sv
// tb_tl_ul_buffer: self-checking bench for tl_ul_buffer.
// A reference model holds each channel as a plain queue of beats: ready is
// "fewer than DEPTH beats held", valid is "at least one held", the head beat
// is the oldest one, reset empties everything. Directed phases follow the
// test plan, then a randomized phase exercises arbitrary valid/ready mixes.
module tb_tl_ul_buffer;
   import tl_ul_pkg::*;

   localparam int A_DEPTH = 2;
   localparam int D_DEPTH = 2;
   localparam int A_W = $bits(tl_a_t);
   localparam int D_W = $bits(tl_d_t);

   // ---------------- clock / reset ----------------
   logic  clock = 1'b0;
   logic  reset = 1'b1;
   always #5 clock = ~clock;

   logic  a_in_valid = 1'b0;
   logic  a_in_ready;
   tl_a_t a_in_bits = '0;
   logic  a_out_valid;
   logic  a_out_ready = 1'b0;
   tl_a_t a_out_bits;
   logic  d_in_valid = 1'b0;
   logic  d_in_ready;
   tl_d_t d_in_bits = '0;
   logic  d_out_valid;
   logic  d_out_ready = 1'b0;
   tl_d_t d_out_bits;
   logic  idle;

   tl_ul_buffer #(
      .A_DEPTH (A_DEPTH),
      .D_DEPTH (D_DEPTH),
      .ADDR_W  (TL_ADDR_W),
      .DATA_W  (TL_DATA_W),
      .SRC_W   (TL_SRC_W)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .a_in_valid  (a_in_valid),
      .a_in_ready  (a_in_ready),
      .a_in_bits   (a_in_bits),
      .a_out_valid (a_out_valid),
      .a_out_ready (a_out_ready),
      .a_out_bits  (a_out_bits),
      .d_in_valid  (d_in_valid),
      .d_in_ready  (d_in_ready),
      .d_in_bits   (d_in_bits),
      .d_out_valid (d_out_valid),
      .d_out_ready (d_out_ready),
      .d_out_bits  (d_out_bits),
      .idle        (idle)
   );

   // ---------------- scoreboard ----------------
   logic [A_W-1:0] a_exp_q[$];
   logic [D_W-1:0] d_exp_q[$];
   bit a_hold = 1'b0;
   bit d_hold = 1'b0;
   int checks = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic tl_a_t rand_a();
      tl_a_t b;
      b.opcode  = ($urandom_range(0, 1) == 1) ? TL_A_PUT_FULL_DATA : TL_A_PUT_PARTIAL_DATA;
      b.param   = 3'($urandom);
      b.size    = 3'($urandom_range(0, 2));
      b.source  = TL_SRC_W'($urandom);
      b.address = TL_ADDR_W'($urandom);
      b.mask    = TL_MASK_W'($urandom);
      b.data    = $urandom;
      b.corrupt = 1'($urandom);
      return b;
   endfunction

   function automatic tl_d_t rand_d();
      tl_d_t b;
      b.opcode  = ($urandom_range(0, 1) == 1) ? TL_D_ACCESS_ACK_DATA : TL_D_ACCESS_ACK;
      b.param   = 2'($urandom);
      b.size    = 3'($urandom_range(0, 2));
      b.source  = TL_SRC_W'($urandom);
      b.sink    = TL_SINK_W'($urandom);
      b.denied  = 1'($urandom);
      b.data    = $urandom;
      b.corrupt = 1'($urandom);
      return b;
   endfunction

   // ---------------- driver ----------------
   // One clock cycle: present inputs (a held beat stays stable until taken),
   // compare outputs against the model at the falling edge, then advance the
   // model with whatever transfers happen at the rising edge.
   task automatic cycle(input bit a_offer, input tl_a_t a_beat, input bit a_rdy,
                        input bit d_offer, input tl_d_t d_beat, input bit d_rdy,
                        input bit rst);
      bit push_a, pop_a, push_d, pop_d;
      if (!a_hold) begin
         a_in_valid = a_offer;
         a_in_bits  = a_beat;
      end
      if (!d_hold) begin
         d_in_valid = d_offer;
         d_in_bits  = d_beat;
      end
      a_out_ready = a_rdy;
      d_out_ready = d_rdy;
      reset       = rst;
      @(negedge clock);
      check("a_in_ready", 128'(a_in_ready), 128'(a_exp_q.size() < A_DEPTH));
      check("a_out_valid", 128'(a_out_valid), 128'(a_exp_q.size() > 0));
      if (a_exp_q.size() > 0) check("a_out_bits", 128'(a_out_bits), 128'(a_exp_q[0]));
      check("d_in_ready", 128'(d_in_ready), 128'(d_exp_q.size() < D_DEPTH));
      check("d_out_valid", 128'(d_out_valid), 128'(d_exp_q.size() > 0));
      if (d_exp_q.size() > 0) check("d_out_bits", 128'(d_out_bits), 128'(d_exp_q[0]));
      check("idle", 128'(idle), 128'(a_exp_q.size() == 0 && d_exp_q.size() == 0));
      push_a = a_in_valid && (a_exp_q.size() < A_DEPTH);
      pop_a  = a_out_ready && (a_exp_q.size() > 0);
      push_d = d_in_valid && (d_exp_q.size() < D_DEPTH);
      pop_d  = d_out_ready && (d_exp_q.size() > 0);
      @(posedge clock);
      if (rst) begin
         a_exp_q.delete();
         d_exp_q.delete();
         a_hold = 1'b0;
         d_hold = 1'b0;
      end else begin
         if (pop_a) void'(a_exp_q.pop_front());
         if (push_a) a_exp_q.push_back(a_in_bits);
         if (pop_d) void'(d_exp_q.pop_front());
         if (push_d) d_exp_q.push_back(d_in_bits);
         a_hold = a_in_valid && !push_a;
         d_hold = d_in_valid && !push_d;
      end
      #1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      tl_a_t ga;
      tl_d_t ack;

      // Power-on reset: DUT state is unknown until the first reset edge.
      reset = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
      @(negedge clock);
      check("reset_a_in_ready", 128'(a_in_ready), 128'(1));
      check("reset_d_in_ready", 128'(d_in_ready), 128'(1));
      check("reset_a_out_valid", 128'(a_out_valid), 128'(0));
      check("reset_d_out_valid", 128'(d_out_valid), 128'(0));
      check("reset_idle", 128'(idle), 128'(1));
      @(posedge clock);
      #1;

      // Single Get, then its AccessAckData on channel D.
      ga = '0;
      ga.opcode  = TL_A_GET;
      ga.size    = 3'd2;
      ga.source  = 2'd2;
      ga.address = 31'h0000_1000;
      ga.mask    = 4'hF;
      cycle(1, ga, 0, 0, rand_d(), 0, 0);
      cycle(0, rand_a(), 1, 0, rand_d(), 0, 0);
      ack = '0;
      ack.opcode = TL_D_ACCESS_ACK_DATA;
      ack.size   = 3'd2;
      ack.source = 2'd2;
      ack.data   = 32'hDEAD_BEEF;
      cycle(0, rand_a(), 0, 1, ack, 0, 0);
      cycle(0, rand_a(), 0, 0, rand_d(), 1, 0);
      cycle(0, rand_a(), 0, 0, rand_d(), 0, 0);

      // Back-to-back streaming of 16 Puts with the slave always ready.
      for (int i = 0; i < 16; i++) cycle(1, rand_a(), 1, 0, rand_d(), 0, 0);
      for (int i = 0; i < 2; i++) cycle(0, rand_a(), 1, 0, rand_d(), 0, 0);

      // Backpressure: three beats offered into a stalled slave, then release.
      for (int i = 0; i < 3; i++) cycle(1, rand_a(), 0, 1, rand_d(), 0, 0);
      for (int i = 0; i < 5; i++) cycle(0, rand_a(), 1, 0, rand_d(), 1, 0);

      // Simultaneous push/pop with one beat resident on both channels.
      cycle(1, rand_a(), 0, 1, rand_d(), 0, 0);
      for (int i = 0; i < 10; i++) cycle(1, rand_a(), 1, 1, rand_d(), 1, 0);
      for (int i = 0; i < 2; i++) cycle(0, rand_a(), 1, 0, rand_d(), 1, 0);

      // Reset mid-traffic with both queues full and a beat waiting.
      for (int i = 0; i < 3; i++) cycle(1, rand_a(), 0, 1, rand_d(), 0, 0);
      cycle(1, rand_a(), 0, 1, rand_d(), 0, 1);
      for (int i = 0; i < 3; i++) cycle(0, rand_a(), 1, 0, rand_d(), 1, 0);

      // Randomized traffic on both channels.
      for (int i = 0; i < 400; i++) begin
         cycle($urandom_range(0, 3) != 0, rand_a(), $urandom_range(0, 2) != 0,
               $urandom_range(0, 3) != 0, rand_d(), $urandom_range(0, 2) != 0,
               $urandom_range(0, 99) == 0);
      end
      for (int i = 0; i < 4; i++) cycle(0, rand_a(), 1, 0, rand_d(), 1, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
